// File: rtl/seq_tx_if.sv
// Host-side handshake and serial line bundle for the seq_tx frame generator.
interface seq_tx_if;
  logic       start;
  logic [7:0] data;
  logic       dout;
  logic       busy;
  logic       done;

  modport master (output start, output data, input dout, input busy, input done);
  modport slave  (input start, input data, output dout, output busy, output done);
endinterface

// File: rtl/seq_tx.sv
// Serial frame generator: 8-bit sync preamble then 8-bit payload, MSB first.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_tx #(
  parameter logic [7:0] PATTERN  = 8'b0101_0101,
  parameter logic       IDLE_LVL = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  seq_tx_if.slave  bus
);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    SYNC = 5'b00010,
    PAY  = 5'b00100,
    DONE = 5'b01000,
    PAR  = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SYNC = 4'b0010,
    PAY  = 4'b0100,
    DONE = 4'b1000
  } state_t;
`endif

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] shift;
  logic [7:0] sync_sr;
  logic       dout_q;
  logic       busy_q;
  logic       done_q;
`ifdef SEQ_TX_PARITY_EN
  logic       par;
`endif

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      shift   <= 8'd0;
      sync_sr <= 8'd0;
      dout_q  <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a request exactly like IDLE, giving a one-bit gap.
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= SYNC;
            cnt     <= 3'd0;
            shift   <= bus.data;
            sync_sr <= {PATTERN[6:0], 1'b0};
            dout_q  <= PATTERN[7];
            busy_q  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par     <= ^bus.data;
`endif
          end else begin
            state  <= IDLE;
            dout_q <= IDLE_LVL;
            busy_q <= 1'b0;
          end
        end
        SYNC: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state  <= PAY;
            dout_q <= shift[7];
            shift  <= {shift[6:0], 1'b0};
          end else begin
            dout_q  <= sync_sr[7];
            sync_sr <= {sync_sr[6:0], 1'b0};
          end
        end
        PAY: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef SEQ_TX_PARITY_EN
            state  <= PAR;
            dout_q <= par;
`else
            state  <= DONE;
            dout_q <= IDLE_LVL;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end else begin
            dout_q <= shift[7];
            shift  <= {shift[6:0], 1'b0};
          end
        end
`ifdef SEQ_TX_PARITY_EN
        PAR: begin
          state  <= DONE;
          dout_q <= IDLE_LVL;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
`endif
        // NOTE: a corrupted (non-one-hot) state falls back to the reset image.
        default: begin
          state   <= IDLE;
          cnt     <= 3'd0;
          shift   <= 8'd0;
          sync_sr <= 8'd0;
          dout_q  <= IDLE_LVL;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: directed frames plus random traffic against
// a frame-position reference model.
module tb_seq_tx;
  localparam logic [7:0] PAT  = 8'b0101_0101;
  localparam logic       IDLE = 1'b1;
`ifdef SEQ_TX_PARITY_EN
  localparam int FLEN = 17;
`else
  localparam int FLEN = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_tx_if bus ();

  seq_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Reference model: pos = -1 idle, 0..FLEN-1 bit index on the line, FLEN = done cycle.
  int         pos = -1;
  logic [7:0] m_data = 8'd0;

  function automatic logic frame_bit(input int i, input logic [7:0] d);
    if (i < 8)       return PAT[7-i];
    else if (i < 16) return d[15-i];
    else             return ^d;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic s, input logic [7:0] d, input logic r);
    if (!r)                                 pos = -1;
    else if ((pos == -1 || pos == FLEN) && s) begin pos = 0; m_data = d; end
    else if (pos >= 0 && pos < FLEN)        pos++;
    else                                    pos = -1;
  endtask

  task automatic cycle(input logic s, input logic [7:0] d, input logic r);
    logic e_dout, e_busy, e_done;
    rst = r; bus.start = s; bus.data = d;
    @(posedge clk);
    model_step(s, d, r);
    @(negedge clk);
    e_dout = IDLE; e_busy = 1'b0; e_done = 1'b0;
    if (pos >= 0 && pos < FLEN) begin
      e_dout = frame_bit(pos, m_data);
      e_busy = 1'b1;
    end else if (pos == FLEN) begin
      e_done = 1'b1;
    end
    chk("dout", {15'd0, bus.dout}, {15'd0, e_dout});
    chk("busy", {15'd0, bus.busy}, {15'd0, e_busy});
    chk("done", {15'd0, bus.done}, {15'd0, e_done});
    if (bus.done === 1'b1) done_seen++;
  endtask

  // Accept a frame and capture its 16 preamble+payload bits.
  task automatic send(input logic [7:0] d, output logic [15:0] bits);
    cycle(1'b1, d, 1'b1);
    bits[15] = bus.dout;
    for (int j = 1; j < 16; j++) begin
      cycle(1'b0, 8'($urandom), 1'b1);
      bits[15-j] = bus.dout;
    end
  endtask

  logic [15:0] cap;

  initial begin
    rst = 1'b0; bus.start = 1'b0; bus.data = 8'd0;

    // Reset held with start asserted, then idle: no frame may start.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("idle_busy", {15'd0, bus.busy}, 16'd0);

    // A5 frame with an ignored FF request mid-frame.
    done_seen = 0;
    cycle(1'b1, 8'hA5, 1'b1);
    cap[15] = bus.dout;
    for (int j = 1; j < 16; j++) begin
      cycle(j == 5, (j == 5) ? 8'hFF : 8'h00, 1'b1);
      cap[15-j] = bus.dout;
    end
    chk("a5_bits", cap, 16'b0101_0101_1010_0101);
`ifdef SEQ_TX_PARITY_EN
    cycle(1'b0, 8'h00, 1'b1);
    chk("a5_par", {15'd0, bus.dout}, 16'd0);
`endif
    cycle(1'b0, 8'h00, 1'b1);
    chk("a5_done", {15'd0, bus.done}, 16'd1);
    chk("a5_gap", {15'd0, bus.dout}, 16'd1);
    chk("a5_done_cnt", 16'(done_seen), 16'd1);

    // Back-to-back: request held in the DONE cycle.
    send(8'h3C, cap);
    chk("b2b_bits", cap, {PAT, 8'h3C});
`ifdef SEQ_TX_PARITY_EN
    cycle(1'b0, 8'h00, 1'b1);
`endif
    cycle(1'b0, 8'h00, 1'b1);
    chk("b2b_done", {15'd0, bus.done}, 16'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Mid-frame reset: no done for the aborted frame.
    done_seen = 0;
    cycle(1'b1, 8'h96, 1'b1);
    for (int j = 0; j < 9; j++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("abort_dout", {15'd0, bus.dout}, 16'd1);
    chk("abort_busy", {15'd0, bus.busy}, 16'd0);
    for (int j = 0; j < 20; j++) cycle(1'b0, 8'h00, 1'b1);
    chk("abort_no_done", 16'(done_seen), 16'd0);

    // Recovery frame 07 (parity bit 1 when enabled).
    send(8'h07, cap);
    chk("f07_bits", cap, {PAT, 8'h07});
`ifdef SEQ_TX_PARITY_EN
    cycle(1'b0, 8'h00, 1'b1);
    chk("f07_par", {15'd0, bus.dout}, 16'd1);
    chk("f07_par_busy", {15'd0, bus.busy}, 16'd1);
`endif
    cycle(1'b0, 8'h00, 1'b1);
    chk("f07_done", {15'd0, bus.done}, 16'd1);

    // Random traffic: sparse starts, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 63) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial frame generator that drives a one-bit line with an 8-bit sync preamble (default 0101_0101) followed by an 8-bit payload, MSB first, one bit per clock. It is the transmit end of the serial sync-pattern link: its `dout` feeds the line watched by the team's Mealy sync detector. A host loads a byte with a one-cycle `start` strobe and gets `busy` and `done` status back.

## Interface
- `PATTERN`, default 8'b0101_0101: preamble bits, sent MSB first.
- `IDLE_LVL`, default 1'b1: level of `dout` when no frame is being sent. Idle-high keeps the detector in its initial state.
- `clk` in 1: the single clock. All logic updates on the rising edge.
- `rst` in 1: synchronous, active-low reset. `rst`==0 at a rising edge resets the block.
- `start` in 1: frame request, sampled only when the block is ready (IDLE or DONE).
- `data` in 8: payload, latched on the accepted `start` cycle.
- `dout` out 1: serial line, registered.
- `busy` out 1: high while preamble, payload or parity bits are on `dout`.
- `done` out 1: one-cycle pulse after the last bit of a frame.

## Operation
- One-hot state register, four states:
  - IDLE: waiting for a request.
  - SYNC: sending the 8 preamble bits.
  - PAY: sending the 8 payload bits.
  - DONE: one cycle of completion status.
  - PAR: present only when `PARITY_EN` is defined.
- Reset values: state=IDLE, `dout`=IDLE_LVL, `busy`=0, `done`=0, bit counter=0, shift register=0.
- IDLE:
  - `start`=1 → latch `data` into the shift register, load PATTERN into the sync register, go to SYNC.
  - `start`=0 → stay in IDLE, `dout`=IDLE_LVL.
- SYNC: `dout`=PATTERN[7-cnt]. The 3-bit counter increments each cycle; when cnt==7 it wraps to 0 and the state moves to PAY.
- PAY: `dout`=payload[7-cnt], MSB first. After cnt==7, go to DONE, or to PAR when `PARITY_EN` is defined.
- DONE:
  - `dout`=IDLE_LVL, `done`=1, `busy`=0.
  - `start`=1 in this cycle is accepted exactly as in IDLE, so the next frame begins on the following cycle.
  - `start`=0 → go to IDLE.
- `start` during SYNC, PAY or PAR is ignored: no latch, no queueing. The in-flight payload is never altered.
- An illegal state encoding (not one-hot) recovers to IDLE on the next clock with outputs at their reset values.

## Timing
- `start` accepted at edge k:
  - first preamble bit on `dout` in cycle k+1;
  - preamble in k+1..k+8;
  - payload in k+9..k+16;
  - `done`=1 in cycle k+17.
- `busy` is high for exactly cycles k+1..k+16, or k+1..k+17 with `PARITY_EN`.
- Back-to-back frames: a `start` in the DONE cycle gives one idle-level bit between frames. This minimum gap is guaranteed.
- All outputs are registered. There is no combinational path from `start` or `data` to any output.
- `rst`=0 mid-frame: at the next edge all outputs return to their reset values. No `done` pulse is produced for the aborted frame.
- `rst`=0 coinciding with `start`: reset wins and the frame is not accepted.

## Configuration
- `SEQ_TX_PARITY_EN` defined:
  - adds state PAR after PAY, which drives the even-parity bit `^data` for one cycle;
  - `busy` is extended by one cycle;
  - `done` moves to k+18;
  - frame length is 17 bits.
- Not defined: no PAR state, 16-bit frame, `done` at k+17.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1 → `dout`=1, `busy`=0, `done`=0 throughout; no frame starts after release until a new `start`.
- Single frame, `data`=8'hA5, `start` at k → `dout` over k+1..k+16 = 0,1,0,1,0,1,0,1, 1,0,1,0,0,1,0,1; `busy`=1 for those 16 cycles; `done`=1 only at k+17; `dout`=1 from k+17 on.
- Ignored request: `start` with `data`=8'hFF at k+5 during an 8'hA5 frame → payload bits are still A5; `done` pulses exactly once, at k+17.
- Back-to-back: `start` with 8'h3C held in the DONE cycle k+17 → `dout`=1 at k+17; second preamble starts at k+18; payload 0,0,1,1,1,1,0,0 over k+26..k+33; `done` at k+34.
- Mid-frame reset: `rst`=0 at the edge ending cycle k+10 → `dout`=1 and `busy`=0 from the next cycle; no `done` pulse; a later `start` produces a complete, correct frame.
- `SEQ_TX_PARITY_EN` with `data`=8'h07 → bits k+9..k+16 = 0,0,0,0,0,1,1,1; parity bit 1 at k+17; `busy`=1 through k+17; `done` at k+18.
